// File: rtl/debug_pkg.sv
// Shared definitions for the debug memory dump reader: FSM encoding and
// byte-framing constants for the data-memory word to UART byte stream.
package debug_pkg;

  localparam int DMEM_LEN       = 32;
  localparam int NB_BYTE        = 8;
  localparam int BYTES_PER_WORD = DMEM_LEN / NB_BYTE;
  localparam int NB_BCNT        = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } dump_state_e;

endpackage

// File: rtl/debug_mem_dump.sv
// Debug-side data-memory reader. While the pipeline is halted it walks word
// addresses 0..DUMP_WORDS-1 and streams each word MSB-first as four bytes
// over the UART start/done handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a start request while halted
// ST_READ    | word address presented, read strobe asserted
// ST_CAPTURE | memory data valid, latched into the word register
// ST_SEND    | byte on o_tx_data, o_tx_start pulsed
// ST_WAIT_TX | waiting for the transmitter to acknowledge the byte
// ST_DONE    | last byte acknowledged, o_done pulsed
module debug_mem_dump
  import debug_pkg::*;
#(
  parameter int LEN        = 32,
  parameter int NB_BYTE    = 8,
  parameter int DUMP_WORDS = 2048,
  parameter int NB_WCNT    = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_halted,
  output logic [LEN-1:0]     o_mem_addr,
  output logic               o_mem_rd_en,
  input  logic [LEN-1:0]     i_mem_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [NB_WCNT-1:0] WCNT_LAST = NB_WCNT'(DUMP_WORDS - 1);
  localparam logic [NB_BCNT-1:0] BCNT_LAST = NB_BCNT'(BYTES_PER_WORD - 1);

  dump_state_e          state_q;
  logic [NB_WCNT-1:0]   wcnt_q;
  logic [NB_BCNT-1:0]   bcnt_q;
  logic [LEN-1:0]       word_q;
  logic [NB_BYTE-1:0]   tx_data_q;

  // Big-endian byte pick: index 0 is the most significant byte.
  function automatic logic [NB_BYTE-1:0] sel_byte(input logic [LEN-1:0]     w,
                                                 input logic [NB_BCNT-1:0] k);
    return w[LEN-1-NB_BYTE*int'(k) -: NB_BYTE];
  endfunction

  // Dump sequencer: walks words and bytes, loads the transmit byte on entry to SEND.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      bcnt_q    <= '0;
      word_q    <= '0;
      tx_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start && i_halted) begin
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // Byte 0 comes straight from the read port so SEND can follow immediately.
          word_q    <= i_mem_data;
          tx_data_q <= sel_byte(i_mem_data, '0);
          state_q   <= ST_SEND;
        end
        ST_SEND: begin
          state_q <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            if (bcnt_q != BCNT_LAST) begin
              bcnt_q    <= bcnt_q + 1'b1;
              tx_data_q <= sel_byte(word_q, bcnt_q + 1'b1);
              state_q   <= ST_SEND;
            end else if (wcnt_q != WCNT_LAST) begin
              wcnt_q  <= wcnt_q + 1'b1;
              bcnt_q  <= '0;
              state_q <= ST_READ;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Address only moves on the WAIT_TX -> READ step, so it is stable for all four bytes.
  assign o_mem_addr  = LEN'(wcnt_q);
  assign o_mem_rd_en = (state_q == ST_READ);
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = (state_q == ST_SEND);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_mem_dump.sv
// Scoreboard bench for debug_mem_dump with a two-word memory and a
// transmitter that acknowledges two cycles after each start pulse.
module tb_debug_mem_dump;

  localparam int LEN        = 32;
  localparam int NB_BYTE    = 8;
  localparam int DUMP_WORDS = 2;
  localparam int NB_WCNT    = 1;

  typedef struct {
    logic [NB_BYTE-1:0] b;
    logic [LEN-1:0]     a;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               halted = 1'b0;
  logic [LEN-1:0]     mem_addr;
  logic               mem_rd_en;
  logic [LEN-1:0]     mem_rdata = '0;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_start;
  logic               tx_done;
  logic               tx_ack = 1'b0;
  logic               spur_done = 1'b0;
  logic               busy;
  logic               done;

  logic [LEN-1:0] mem [DUMP_WORDS];

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   tx_cnt = 0;
  int   rd_cnt = 0;
  int   done_cnt = 0;
  logic [NB_BYTE-1:0] last_byte = '0;
  bit   have_last = 0;
  int   ack_cnt = 0;

  assign tx_done = tx_ack | spur_done;

  always #5 clk = ~clk;

  debug_mem_dump #(
    .LEN(LEN), .NB_BYTE(NB_BYTE), .DUMP_WORDS(DUMP_WORDS), .NB_WCNT(NB_WCNT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_halted(halted),
    .o_mem_addr(mem_addr),
    .o_mem_rd_en(mem_rd_en),
    .i_mem_data(mem_rdata),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .i_tx_done(tx_done),
    .o_busy(busy),
    .o_done(done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_dump();
    for (int w = 0; w < DUMP_WORDS; w++) begin
      for (int k = 0; k < 4; k++) begin
        exp_t e;
        logic [LEN-1:0] word;
        word = mem[w];
        e.b = word[LEN-1-8*k -: 8];
        e.a = LEN'(w);
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (done) begin
        seen = 1;
        break;
      end
    end
    check_val("done_seen", 32'(seen), 1);
  endtask

  // Synchronous-read data memory: data valid the cycle after the address.
  always @(posedge clk) begin
    if (mem_rd_en)
      mem_rdata <= (mem_addr < LEN'(DUMP_WORDS)) ? mem[mem_addr[0]] : 32'hDEAD_BEEF;
  end

  // Transmitter: acknowledge two cycles after each start pulse.
  initial begin
    forever begin
      @(negedge clk);
      tx_ack = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) tx_ack = 1'b1;
      end
      if (tx_start) ack_cnt = 2;
    end
  end

  // Output monitor: scoreboard pops on each start pulse, byte hold between sends.
  always @(negedge clk) begin
    if (!rst) begin
      have_last = 0;
    end else begin
      if (mem_rd_en) rd_cnt++;
      if (done) begin
        done_cnt++;
        check_val("sb_drained", 32'(sb.size()), 0);
      end
      if (tx_start) begin
        tx_cnt++;
        check_val("sb_pending", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check_val("tx_byte", 32'(tx_data), 32'(e.b));
          check_val("tx_addr", mem_addr, e.a);
        end
        last_byte = tx_data;
        have_last = 1;
      end else if (busy && have_last) begin
        check_val("tx_hold", 32'(tx_data), 32'(last_byte));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d0, r0, n;
    bit found;
    mem[0] = 32'h1122_3344;
    mem[1] = 32'hAABB_CCDD;

    // Reset state
    #2;
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_tx_start", 32'(tx_start), 0);
    check_val("rst_tx_data", 32'(tx_data), 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_rd_en", 32'(mem_rd_en), 0);
    step();
    step();
    rst = 1'b1;
    step();

    // Start while not halted is ignored
    halted = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_val("nohalt_busy", 32'(busy), 0);
    check_val("nohalt_rd", 32'(rd_cnt), 0);

    // Spurious done in IDLE is ignored
    halted = 1'b1;
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    step();
    check_val("idle_spur_busy", 32'(busy), 0);

    // Two-word dump with latency, spurious done in CAPTURE, start while busy
    t0 = tx_cnt; d0 = done_cnt; r0 = rd_cnt;
    push_dump();
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("read_rd_en", 32'(mem_rd_en), 1);
    check_val("read_addr", mem_addr, 0);
    check_val("read_busy", 32'(busy), 1);
    step();
    check_val("capture_no_start", 32'(tx_start), 0);
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    check_val("latency3_start", 32'(tx_start), 1);
    check_val("latency3_byte0", 32'(tx_data), 32'h11);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    check_val("dump_tx_count", 32'(tx_cnt - t0), 8);
    check_val("dump_rd_count", 32'(rd_cnt - r0), 2);
    step();
    check_val("dump_done_count", 32'(done_cnt - d0), 1);
    check_val("dump_busy_after", 32'(busy), 0);
    for (int i = 0; i < 10; i++) step();
    check_val("no_restart_tx", 32'(tx_cnt - t0), 8);

    // Reset during WAIT_TX of byte 2 of word 1
    d0 = done_cnt;
    push_dump();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx_start) begin
        n++;
        if (n == 7) begin
          found = 1;
          break;
        end
      end
    end
    check_val("mid_reach_b2w1", 32'(found), 1);
    step();
    check_val("mid_pre_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(busy), 0);
    check_val("mid_rst_tx_data", 32'(tx_data), 0);
    check_val("mid_rst_tx_start", 32'(tx_start), 0);
    check_val("mid_rst_addr", mem_addr, 0);
    check_val("mid_rst_rd_en", 32'(mem_rd_en), 0);
    check_val("mid_rst_done", 32'(done), 0);
    sb.delete();
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_val("mid_no_done", 32'(done_cnt - d0), 0);

    // Restart after abort goes from address 0, byte 0
    t0 = tx_cnt; d0 = done_cnt;
    push_dump();
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("restart_addr", mem_addr, 0);
    wait_done();
    check_val("restart_tx_count", 32'(tx_cnt - t0), 8);
    step();
    check_val("restart_done_count", 32'(done_cnt - d0), 1);
    check_val("restart_busy_after", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
